// File: rtl/tlk2711_tx_link.sv
// TLK2711 transmit link layer: fetches each frame's payload over DMA into a
// 64-bit staging FIFO, then serializes the framed words onto the 16-bit TX bus.
module tlk2711_tx_link #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DLEN_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH = 2048,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_soft_rst,
  input  logic                             i_tx_start,
  input  logic [ADDR_WIDTH-1:0]            i_tx_base_addr,
  input  logic [15:0]                      i_tx_frame_length,
  input  logic [15:0]                      i_tx_frame_num,
  input  logic [15:0]                      i_tx_line_num,
  input  logic [7:0]                       i_tx_data_mode,
  output logic                             o_rd_cmd_req,
  input  logic                             i_rd_cmd_ack,
  output logic [ADDR_WIDTH+DLEN_WIDTH-1:0] o_rd_cmd_data,
  input  logic                             i_dma_rd_valid,
  input  logic [DATA_WIDTH-1:0]            i_dma_rd_data,
  output logic                             o_dma_rd_ready,
  output logic                             o_2711_tkmsb,
  output logic                             o_2711_tklsb,
  output logic [15:0]                      o_2711_txd,
  output logic                             o_tx_busy,
  output logic                             o_tx_interrupt,
  output logic [15:0]                      o_tx_frame_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  localparam logic [15:0] SYNC_WORD = 16'hC5BC;
  localparam logic [15:0] SOF_WORD  = 16'h5CFB;
  localparam logic [15:0] END_WORD  = 16'hFDFE;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_FILL, S_SOF, S_HEAD1, S_HEAD2, S_TYPE,
    S_LINE, S_LEN, S_DATA, S_CKSUM, S_END1, S_END2, S_GAP
  } state_t;

  state_t                  r_state, w_next;
  logic                    w_rst;

  logic [15:0]             r_len, r_num, r_line;
  logic [7:0]              r_mode;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [15:0]             r_frame_idx, r_frame_cnt;
  logic [14:0]             r_wcnt;
  logic [1:0]              r_lane;
  logic [GW-1:0]           r_gap;
  logic [15:0]             r_cksum, r_txd;
  logic                    r_tkmsb, r_tklsb, r_int;

  logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]           r_count;

  logic                    w_full, w_push, w_pop;
  logic [DATA_WIDTH-1:0]   w_head;
  logic [15:0]             w_lane_word;
  logic [13:0]             w_beats;
  logic [15:0]             w_bbt;
  logic [14:0]             w_words;
  logic                    w_last_word, w_last_frame, w_more, w_gap_done, w_fill_ok;

  assign w_rst        = rst | i_soft_rst;

  // Frame length rounded up to whole 64-bit beats
  assign w_beats      = {1'b0, r_len[15:3]} + 14'(|r_len[2:0]);
  assign w_bbt        = {w_beats[12:0], 3'b000};
  assign w_words      = r_len[15:1];

  assign w_last_word  = (r_wcnt == w_words - 15'd1);
  assign w_last_frame = (r_frame_idx == r_num - 16'd1);
  assign w_more       = (r_frame_idx < r_num);
  assign w_gap_done   = (r_gap == GW'(GAP_CYCLES - 1));
  assign w_fill_ok    = (32'(r_count) >= 32'(w_beats));

  assign w_full       = (r_count == CW'(FIFO_DEPTH));
  assign w_push       = i_dma_rd_valid & ~w_full;
  assign w_head       = r_mem[r_rd_ptr];
  assign w_lane_word  = w_head[{r_lane, 4'b0000} +: 16];
  // Pop after lane 3, or early on the frame's last word so padded lanes are dropped
  assign w_pop        = (r_state == S_DATA) && ((r_lane == 2'd3) || w_last_word);

  assign o_dma_rd_ready = ~w_full;
  assign o_rd_cmd_req   = (r_state == S_CMD);
  assign o_rd_cmd_data  = {r_addr, DLEN_WIDTH'(w_bbt)};
  assign o_tx_busy      = (r_state != S_IDLE);
  assign o_tx_interrupt = r_int;
  assign o_tx_frame_cnt = r_frame_cnt;
  assign o_2711_txd     = r_txd;
  assign o_2711_tkmsb   = r_tkmsb;
  assign o_2711_tklsb   = r_tklsb;

  // State register
  always_ff @(posedge clk) begin
    if (w_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state sequencing of the frame
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_tx_start)   w_next = S_CMD;
      S_CMD:   if (i_rd_cmd_ack) w_next = S_FILL;
      S_FILL:  if (w_fill_ok)    w_next = S_SOF;
      S_SOF:   w_next = S_HEAD1;
      S_HEAD1: w_next = S_HEAD2;
      S_HEAD2: w_next = S_TYPE;
      S_TYPE:  w_next = S_LINE;
      S_LINE:  w_next = S_LEN;
      S_LEN:   w_next = S_DATA;
      S_DATA:  if (w_last_word)  w_next = S_CKSUM;
      S_CKSUM: w_next = S_END1;
      S_END1:  w_next = S_END2;
      S_END2:  w_next = S_GAP;
      S_GAP:   if (w_gap_done)   w_next = w_more ? S_CMD : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Job configuration, frame bookkeeping and word/gap counters
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_len       <= '0;
      r_num       <= '0;
      r_line      <= '0;
      r_mode      <= '0;
      r_addr      <= '0;
      r_frame_idx <= '0;
      r_frame_cnt <= '0;
      r_wcnt      <= '0;
      r_lane      <= '0;
      r_gap       <= '0;
      r_int       <= 1'b0;
    end else begin
      r_int <= (r_state == S_GAP) && w_gap_done && !w_more;
      unique case (r_state)
        S_IDLE: if (i_tx_start) begin
          r_len       <= i_tx_frame_length;
          r_num       <= i_tx_frame_num;
          r_line      <= i_tx_line_num;
          r_mode      <= i_tx_data_mode;
          r_addr      <= i_tx_base_addr;
          r_frame_idx <= '0;
          r_frame_cnt <= '0;
        end
        S_LEN: begin
          r_wcnt <= '0;
          r_lane <= '0;
        end
        S_DATA: begin
          r_wcnt <= r_wcnt + 15'd1;
          r_lane <= r_lane + 2'd1;
        end
        S_END2: begin
          r_frame_idx <= r_frame_idx + 16'd1;
          r_frame_cnt <= r_frame_cnt + 16'd1;
          r_addr      <= r_addr + ADDR_WIDTH'(w_bbt);
          r_gap       <= '0;
        end
        S_GAP: r_gap <= r_gap + 1'b1;
        default: ;
      endcase
    end
  end

  // Registered TX word and running checksum
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_txd   <= SYNC_WORD;
      r_tkmsb <= 1'b0;
      r_tklsb <= 1'b1;
      r_cksum <= '0;
    end else begin
      r_txd   <= SYNC_WORD;
      r_tkmsb <= 1'b0;
      r_tklsb <= 1'b1;
      unique case (r_state)
        S_SOF: begin
          r_txd   <= SOF_WORD;
          r_tkmsb <= 1'b1;
        end
        S_HEAD1: begin r_txd <= 16'hEB90; r_tklsb <= 1'b0; end
        S_HEAD2: begin r_txd <= 16'hE116; r_tklsb <= 1'b0; end
        S_TYPE: begin
          r_txd   <= {r_mode, w_last_frame ? 8'hAA : 8'h00};
          r_tklsb <= 1'b0;
          r_cksum <= {r_mode, w_last_frame ? 8'hAA : 8'h00};
        end
        S_LINE: begin
          r_txd   <= r_line + r_frame_idx;
          r_tklsb <= 1'b0;
          r_cksum <= r_cksum + r_line + r_frame_idx;
        end
        S_LEN: begin
          r_txd   <= r_len;
          r_tklsb <= 1'b0;
          r_cksum <= r_cksum + r_len;
        end
        S_DATA: begin
          r_txd   <= w_lane_word;
          r_tklsb <= 1'b0;
          r_cksum <= r_cksum + w_lane_word;
        end
        S_CKSUM: begin r_txd <= r_cksum; r_tklsb <= 1'b0; end
        S_END1, S_END2: begin
          r_txd   <= END_WORD;
          r_tkmsb <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the pointers are flushed
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_dma_rd_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tlk2711_tx_link.sv
// Self-checking bench for tlk2711_tx_link: a queue of expected TX words built
// from the framing rules, a DMA responder, and a per-cycle output checker.
module tb_tlk2711_tx_link;

  localparam int unsigned GAP = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_soft_rst = 1'b0;
  logic        i_tx_start = 1'b0;
  logic [31:0] i_tx_base_addr = '0;
  logic [15:0] i_tx_frame_length = '0;
  logic [15:0] i_tx_frame_num = '0;
  logic [15:0] i_tx_line_num = '0;
  logic [7:0]  i_tx_data_mode = '0;
  logic        o_rd_cmd_req;
  logic        i_rd_cmd_ack = 1'b0;
  logic [47:0] o_rd_cmd_data;
  logic        i_dma_rd_valid = 1'b0;
  logic [63:0] i_dma_rd_data = '0;
  logic        o_dma_rd_ready;
  logic        o_2711_tkmsb, o_2711_tklsb;
  logic [15:0] o_2711_txd;
  logic        o_tx_busy, o_tx_interrupt;
  logic [15:0] o_tx_frame_cnt;

  always #5 clk = ~clk;

  tlk2711_tx_link #(
    .ADDR_WIDTH(32), .DLEN_WIDTH(16), .DATA_WIDTH(64),
    .FIFO_DEPTH(2048), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .i_soft_rst(i_soft_rst), .i_tx_start(i_tx_start),
    .i_tx_base_addr(i_tx_base_addr), .i_tx_frame_length(i_tx_frame_length),
    .i_tx_frame_num(i_tx_frame_num), .i_tx_line_num(i_tx_line_num),
    .i_tx_data_mode(i_tx_data_mode), .o_rd_cmd_req(o_rd_cmd_req),
    .i_rd_cmd_ack(i_rd_cmd_ack), .o_rd_cmd_data(o_rd_cmd_data),
    .i_dma_rd_valid(i_dma_rd_valid), .i_dma_rd_data(i_dma_rd_data),
    .o_dma_rd_ready(o_dma_rd_ready), .o_2711_tkmsb(o_2711_tkmsb),
    .o_2711_tklsb(o_2711_tklsb), .o_2711_txd(o_2711_txd), .o_tx_busy(o_tx_busy),
    .o_tx_interrupt(o_tx_interrupt), .o_tx_frame_cnt(o_tx_frame_cnt)
  );

  typedef struct {
    logic [1:0]  k;
    logic [15:0] w;
    bit          sof;
    bit          dat;
    int          endtag;
    bit          last;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int          bbt;
  } cmd_t;

  ent_t        exp_q[$];
  cmd_t        cmd_q[$];
  ent_t        e;

  int          vectors = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          g_suspend = 1'b1;
  bit          g_fixed = 1'b0;
  logic [63:0] g_fixed_beat = '0;
  logic [31:0] g_seed = '0;
  int          g_thr = 0;
  int          g_ack_dly = 0;
  bit          g_beats_done = 1'b0;
  int          g_frames_cmd = 0;
  int          g_data_seen = 0;
  int          g_end2_cyc = 0;
  int          exp_int_cyc = -1;
  bit          in_frame = 1'b0;
  logic [15:0] g_last_cksum = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Payload content of DDR at a given beat address
  function automatic logic [63:0] beat_at(input logic [31:0] a);
    logic [63:0] x;
    if (g_fixed) return g_fixed_beat;
    x = {a, a ^ g_seed} * 64'h9E37_79B9_7F4A_7C15;
    return x ^ (x >> 29);
  endfunction

  function automatic void push(input logic [1:0] k, input logic [15:0] w,
                               input bit sof, input bit dat, input int endtag, input bit last);
    ent_t t;
    t.k = k; t.w = w; t.sof = sof; t.dat = dat; t.endtag = endtag; t.last = last;
    exp_q.push_back(t);
  endfunction

  // Expected command list and TX word stream for a whole job
  function automatic void build_model(input int len, input int num, input int line,
                                      input int mode, input logic [31:0] base);
    int          bbt;
    int          nw;
    logic [31:0] a;
    logic [15:0] typ, ln, sum, d;
    logic [63:0] bt;
    cmd_t        c;
    bbt = ((len + 7) / 8) * 8;
    nw  = len / 2;
    for (int f = 0; f < num; f++) begin
      a   = base + 32'(f * bbt);
      typ = {8'(mode), (f == num - 1) ? 8'hAA : 8'h00};
      ln  = 16'(line + f);
      sum = typ + ln + 16'(len);
      c.addr = a; c.bbt = bbt;
      cmd_q.push_back(c);
      push(2'b11, 16'h5CFB, 1, 0, 0, 0);
      push(2'b00, 16'hEB90, 0, 0, 0, 0);
      push(2'b00, 16'hE116, 0, 0, 0, 0);
      push(2'b00, typ, 0, 0, 0, 0);
      push(2'b00, ln, 0, 0, 0, 0);
      push(2'b00, 16'(len), 0, 0, 0, 0);
      for (int i = 0; i < nw; i++) begin
        bt  = beat_at(a + 32'(8 * (i / 4)));
        d   = bt[16 * (i % 4) +: 16];
        sum = sum + d;
        push(2'b00, d, 0, 1, 0, 0);
      end
      push(2'b00, sum, 0, 0, 0, 0);
      push(2'b11, 16'hFDFE, 0, 0, 0, 0);
      push(2'b11, 16'hFDFE, 0, 0, f + 1, f == num - 1);
      g_last_cksum = sum;
    end
  endfunction

  // Per-cycle output checker against the expected word stream
  always @(negedge clk) begin
    if (!g_suspend) begin
      if (o_2711_txd == 16'hC5BC && !o_2711_tkmsb && o_2711_tklsb) begin
        if (in_frame) begin
          vectors++;
          fails++;
          $display("FAIL frame_gap: got sync word inside frame, expected %h (cycle %0d)",
                   exp_q.size() > 0 ? exp_q[0].w : 16'h0, cyc);
        end
      end else if (exp_q.size() == 0) begin
        check("unexpected_word", {o_2711_tkmsb, o_2711_tklsb, o_2711_txd}, 18'h1C5BC);
      end else begin
        e = exp_q.pop_front();
        check("tx_word", {o_2711_tkmsb, o_2711_tklsb, o_2711_txd}, {e.k, e.w});
        if (e.sof) begin
          in_frame = 1'b1;
          check("sof_after_full_frame", g_beats_done, 1);
        end
        if (e.dat) g_data_seen++;
        if (e.endtag != 0) begin
          in_frame   = 1'b0;
          g_end2_cyc = cyc;
          check("frame_cnt_at_end2", o_tx_frame_cnt, 64'(e.endtag));
          if (e.last) exp_int_cyc = cyc + GAP;
        end
      end
      if (o_tx_interrupt || cyc == exp_int_cyc) begin
        check("interrupt", o_tx_interrupt, cyc == exp_int_cyc);
        if (o_tx_interrupt) check("busy_at_irq", o_tx_busy, 0);
      end
    end
  end

  // DMA read engine: checks each command, acks it, returns the frame's beats
  initial begin : dma
    cmd_t c;
    bit   acc;
    int   t;
    forever begin
      @(negedge clk);
      if (o_rd_cmd_req && !g_suspend) begin
        if (cmd_q.size() == 0) begin
          check("unexpected_cmd", o_rd_cmd_data, 48'h0);
          c.addr = '0; c.bbt = 0;
        end else begin
          c = cmd_q.pop_front();
          check("rd_cmd", o_rd_cmd_data, {c.addr, 16'(c.bbt)});
        end
        if (g_frames_cmd > 0) check("gap_len", 64'(cyc - g_end2_cyc), GAP);
        g_frames_cmd++;
        g_beats_done = 1'b0;
        repeat (g_ack_dly) @(posedge clk);
        @(posedge clk); #1 i_rd_cmd_ack = 1'b1;
        @(posedge clk); #1 i_rd_cmd_ack = 1'b0;
        for (int b = 0; b < c.bbt / 8; b++) begin
          if (g_thr == 1) begin
            i_dma_rd_valid = 1'b0;
            repeat (2) begin @(posedge clk); #1; end
          end else if (g_thr == 2 && $urandom_range(0, 1) == 1) begin
            i_dma_rd_valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
          end
          i_dma_rd_valid = 1'b1;
          i_dma_rd_data  = beat_at(c.addr + 32'(8 * b));
          acc = 1'b0;
          t   = 0;
          while (!acc && t < 1000) begin
            @(negedge clk);
            acc = o_dma_rd_ready;
            @(posedge clk); #1;
            t++;
          end
          if (!acc) check("beat_accept", 0, 1);
        end
        i_dma_rd_valid = 1'b0;
        g_beats_done   = 1'b1;
      end
    end
  end

  task automatic start_job(input int len, input int num, input int line, input int mode,
                           input logic [31:0] base, input int thr, input int ackd);
    g_thr = thr; g_ack_dly = ackd; g_frames_cmd = 0; g_data_seen = 0;
    g_seed = $urandom;
    build_model(len, num, line, mode, base);
    @(posedge clk); #1;
    i_tx_base_addr = base; i_tx_frame_length = 16'(len); i_tx_frame_num = 16'(num);
    i_tx_line_num = 16'(line); i_tx_data_mode = 8'(mode); i_tx_start = 1'b1;
    @(posedge clk); #1 i_tx_start = 1'b0;
    @(negedge clk);
    check("busy_after_start", o_tx_busy, 1);
  endtask

  task automatic wait_done(input int num);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (o_tx_interrupt) begin done = 1'b1; break; end
    end
    check("job_done", done, 1);
    check("frame_cnt_final", o_tx_frame_cnt, 64'(num));
    check("model_drained", exp_q.size(), 0);
    check("cmds_drained", cmd_q.size(), 0);
    repeat (3) @(negedge clk);
    check("idle_after_job", o_tx_busy, 0);
  endtask

  task automatic run_job(input int len, input int num, input int line, input int mode,
                         input logic [31:0] base, input int thr, input int ackd);
    start_job(len, num, line, mode, base, thr, ackd);
    wait_done(num);
  endtask

  initial begin : main
    int len, num;
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_txd", {o_2711_tkmsb, o_2711_tklsb, o_2711_txd}, 18'h1C5BC);
    check("rst_busy", o_tx_busy, 0);
    check("rst_req", o_rd_cmd_req, 0);
    check("rst_irq", o_tx_interrupt, 0);
    check("rst_frame_cnt", o_tx_frame_cnt, 0);
    check("rst_ready", o_dma_rd_ready, 1);
    g_suspend = 1'b0;

    // Single 882-byte frame: 888-byte command, 441 data words
    build_model(882, 1, 5, 8'h5A, 32'h1000);
    check("pin_cmd0", {cmd_q[0].addr, 16'(cmd_q[0].bbt)}, {32'h1000, 16'd888});
    check("pin_len_word", exp_q[5].w, 16'h0372);
    check("pin_stream_len", exp_q.size(), 450);
    exp_q.delete(); cmd_q.delete();
    run_job(882, 1, 5, 8'h5A, 32'h1000, 0, 0);

    // Three 8-byte frames, with an ignored start while busy
    build_model(8, 3, 5, 8'h11, 32'h1000);
    check("pin_cmd2_addr", cmd_q[2].addr, 32'h1010);
    check("pin_f1_flag", exp_q[16].w[7:0], 8'h00);
    check("pin_f2_flag", exp_q[29].w[7:0], 8'hAA);
    check("pin_f2_line", exp_q[30].w, 16'd7);
    exp_q.delete(); cmd_q.delete();
    start_job(8, 3, 5, 8'h11, 32'h1000, 0, 0);
    repeat (20) @(posedge clk);
    #1;
    i_tx_base_addr = 32'hDEAD_0000; i_tx_frame_length = 16'd100; i_tx_frame_num = 16'd9;
    i_tx_line_num = 16'd77; i_tx_start = 1'b1;
    @(posedge clk); #1 i_tx_start = 1'b0;
    wait_done(3);

    // Two-byte frame: one word, three lanes discarded
    g_fixed = 1'b1; g_fixed_beat = 64'h4444_3333_2222_1111;
    build_model(2, 1, 5, 8'h3C, 32'h2000);
    check("pin_cksum_len2", g_last_cksum, 16'h4DC2);
    check("pin_data_len2", exp_q[6].w, 16'h1111);
    exp_q.delete(); cmd_q.delete();
    run_job(2, 1, 5, 8'h3C, 32'h2000, 0, 0);

    // Checksum wrap with all-ones payload
    g_fixed_beat = 64'hFFFF_FFFF_FFFF_FFFF;
    build_model(16, 1, 0, 8'h00, 32'h3000);
    check("pin_cksum_wrap", g_last_cksum, 16'h00B2);
    exp_q.delete(); cmd_q.delete();
    run_job(16, 1, 0, 8'h00, 32'h3000, 0, 0);
    g_fixed = 1'b0;

    // Slow ack and 1-in-3 valid throttling
    run_job(2 * $urandom_range(20, 100), 2, $urandom_range(0, 65535),
            $urandom_range(0, 255), 32'h4000, 1, 20);

    // Soft reset in the middle of DATA, then a clean job
    start_job(64, 2, 3, 8'h77, 32'h5000, 0, 0);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (g_data_seen >= 5) break;
    end
    check("reached_data", g_data_seen >= 5, 1);
    @(posedge clk); #1;
    g_suspend  = 1'b1;
    i_soft_rst = 1'b1;
    @(posedge clk); #1 i_soft_rst = 1'b0;
    @(negedge clk);
    check("srst_txd", {o_2711_tkmsb, o_2711_tklsb, o_2711_txd}, 18'h1C5BC);
    check("srst_busy", o_tx_busy, 0);
    check("srst_frame_cnt", o_tx_frame_cnt, 0);
    check("srst_req", o_rd_cmd_req, 0);
    exp_q.delete(); cmd_q.delete();
    in_frame = 1'b0; exp_int_cyc = -1; g_beats_done = 1'b0;
    repeat (5) @(negedge clk);
    check("srst_quiet", {o_tx_busy, o_2711_txd}, 17'h0C5BC);
    g_suspend = 1'b0;
    run_job(40, 1, 9, 8'h42, 32'h6000, 0, 0);

    // Randomized jobs
    for (int j = 0; j < 4; j++) begin
      len = 2 * $urandom_range(1, 256);
      num = $urandom_range(1, 3);
      run_job(len, num, $urandom_range(0, 65535), $urandom_range(0, 255),
              32'($urandom_range(0, 32'h00FF_FFFF)), 2, $urandom_range(0, 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
